// File: rtl/md_pkg.sv
// Shared definitions for the RV32M multiply/divide unit: op codes, FSM encoding, widths.
package md_pkg;

  localparam int MD_XLEN  = 32;
  localparam int MD_CNT_W = 5;

  localparam logic [2:0] MD_MUL    = 3'b000;
  localparam logic [2:0] MD_MULH   = 3'b001;
  localparam logic [2:0] MD_MULHSU = 3'b010;
  localparam logic [2:0] MD_MULHU  = 3'b011;
  localparam logic [2:0] MD_DIV    = 3'b100;
  localparam logic [2:0] MD_DIVU   = 3'b101;
  localparam logic [2:0] MD_REM    = 3'b110;
  localparam logic [2:0] MD_REMU   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } md_state_e;

endpackage

// File: rtl/md_sign_fix.sv
// Sign handling for md_unit: operand magnitudes/sign flags on the way in,
// sign correction and result-half selection on the way out.
module md_sign_fix
  import md_pkg::*;
(
  input  logic [2:0]           op_funct3,
  input  logic [MD_XLEN-1:0]   op_a,
  input  logic [MD_XLEN-1:0]   op_b,
  output logic [MD_XLEN-1:0]   mag_a,
  output logic [MD_XLEN-1:0]   mag_b,
  output logic                 sign_a,
  output logic                 sign_b,
  input  logic [2:0]           fin_funct3,
  input  logic [2*MD_XLEN-1:0] raw,
  input  logic                 neg_a,
  input  logic                 neg_b,
  output logic [MD_XLEN-1:0]   fixed
);

  logic                 signed_a;
  logic                 signed_b;
  logic [2*MD_XLEN-1:0] prod;
  logic [MD_XLEN-1:0]   quo;
  logic [MD_XLEN-1:0]   rem;

  // Which operands are interpreted as signed for the captured op
  always_comb begin
    signed_a = 1'b0;
    signed_b = 1'b0;
    case (op_funct3)
      MD_MUL, MD_MULH, MD_DIV, MD_REM: begin
        signed_a = 1'b1;
        signed_b = 1'b1;
      end
      MD_MULHSU: begin
        signed_a = 1'b1;
        signed_b = 1'b0;
      end
      default: begin
        signed_a = 1'b0;
        signed_b = 1'b0;
      end
    endcase
  end

  assign sign_a = signed_a & op_a[MD_XLEN-1];
  assign sign_b = signed_b & op_b[MD_XLEN-1];
  assign mag_a  = sign_a ? (~op_a + 32'd1) : op_a;
  assign mag_b  = sign_b ? (~op_b + 32'd1) : op_b;

  // Quotient/product take the XOR sign; the remainder follows the dividend
  always_comb begin
    prod  = (neg_a ^ neg_b) ? (~raw + 64'd1) : raw;
    quo   = (neg_a ^ neg_b) ? (~raw[31:0] + 32'd1) : raw[31:0];
    rem   = neg_a ? (~raw[63:32] + 32'd1) : raw[63:32];
    fixed = 32'd0;
    case (fin_funct3)
      MD_MUL:                        fixed = prod[31:0];
      MD_MULH, MD_MULHSU, MD_MULHU:  fixed = prod[63:32];
      MD_DIV, MD_DIVU:               fixed = quo;
      MD_REM, MD_REMU:               fixed = rem;
      default:                       fixed = 32'd0;
    endcase
  end

endmodule

// File: rtl/md_unit.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and
// restoring divide on magnitudes, 32 steps, with divide-by-zero/overflow fast path.
module md_unit
  import md_pkg::*;
#(
  parameter int XLEN  = MD_XLEN,
  parameter int CNT_W = MD_CNT_W
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic [4:0]      rd_in,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out
);

  md_state_e          state;
  logic [2:0]         f3;
  logic [XLEN-1:0]    mag_a;
  logic [XLEN-1:0]    mag_b;
  logic               neg_a;
  logic               neg_b;
  logic [2*XLEN-1:0]  acc;
  logic [2*XLEN-1:0]  acc_next;
  logic [CNT_W-1:0]   counter;

  logic [XLEN-1:0]    cap_mag_a;
  logic [XLEN-1:0]    cap_mag_b;
  logic               cap_sign_a;
  logic               cap_sign_b;
  logic [XLEN-1:0]    fin_result;

  logic               fast;
  logic [XLEN-1:0]    fast_val;
  logic [XLEN:0]      sum;
  logic [XLEN:0]      rem_sh;
  logic               rem_ge;
  logic [XLEN-1:0]    rem_sub;

  md_sign_fix u_sign_fix (
    .op_funct3  (funct3),
    .op_a       (op_a),
    .op_b       (op_b),
    .mag_a      (cap_mag_a),
    .mag_b      (cap_mag_b),
    .sign_a     (cap_sign_a),
    .sign_b     (cap_sign_b),
    .fin_funct3 (f3),
    .raw        (acc_next),
    .neg_a      (neg_a),
    .neg_b      (neg_b),
    .fixed      (fin_result)
  );

  // Divide-by-zero and signed-overflow results are known without iterating
  always_comb begin
    fast     = 1'b0;
    fast_val = 32'd0;
    if (funct3[2]) begin
      if (op_b == 32'd0) begin
        fast     = 1'b1;
        fast_val = funct3[1] ? op_a : 32'hFFFF_FFFF;
      end else if (!funct3[0] && (op_a == 32'h8000_0000) && (op_b == 32'hFFFF_FFFF)) begin
        fast     = 1'b1;
        fast_val = funct3[1] ? 32'd0 : 32'h8000_0000;
      end else begin
        fast     = 1'b0;
        fast_val = 32'd0;
      end
    end else begin
      fast     = 1'b0;
      fast_val = 32'd0;
    end
  end

  // One radix-2 step; acc holds {hi, lo} = product or {remainder, quotient}
  always_comb begin
    sum     = {1'b0, acc[63:32]} + {1'b0, mag_a};
    rem_sh  = {acc[63:32], acc[31]};
    rem_ge  = (rem_sh >= {1'b0, mag_b});
    rem_sub = rem_sh[31:0] - mag_b;
    if (f3[2]) begin
      acc_next = rem_ge ? {rem_sub, acc[30:0], 1'b1} : {rem_sh[31:0], acc[30:0], 1'b0};
    end else begin
      acc_next = acc[0] ? {sum, acc[31:1]} : {1'b0, acc[63:1]};
    end
  end

  // Control FSM with registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      result  <= 32'd0;
      rd_out  <= 5'd0;
      f3      <= 3'd0;
      mag_a   <= 32'd0;
      mag_b   <= 32'd0;
      neg_a   <= 1'b0;
      neg_b   <= 1'b0;
      acc     <= 64'd0;
      counter <= {CNT_W{1'b0}};
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            f3      <= funct3;
            rd_out  <= rd_in;
            mag_a   <= cap_mag_a;
            mag_b   <= cap_mag_b;
            neg_a   <= cap_sign_a;
            neg_b   <= cap_sign_b;
            counter <= {CNT_W{1'b0}};
            busy    <= 1'b1;
            acc     <= funct3[2] ? {32'd0, cap_mag_a} : {32'd0, cap_mag_b};
            if (fast) begin
              result <= fast_val;
              done   <= 1'b1;
              state  <= ST_DONE;
            end else begin
              state  <= ST_CALC;
            end
          end
        end
        ST_CALC: begin
          acc     <= acc_next;
          counter <= counter + {{(CNT_W-1){1'b0}}, 1'b1};
          if (counter == {CNT_W{1'b1}}) begin
            result <= fin_result;
            done   <= 1'b1;
            state  <= ST_DONE;
          end
        end
        ST_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: per-cycle comparison against a latency/arithmetic
// reference model, directed cases with literal expectations, and random traffic.
module tb_md_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  funct3 = 3'd0;
  logic [31:0] op_a = 32'd0;
  logic [31:0] op_b = 32'd0;
  logic [4:0]  rd_in = 5'd0;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic [4:0]  rd_out;

  int checks = 0;
  int failures = 0;

  md_unit dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .funct3 (funct3),
    .op_a   (op_a),
    .op_b   (op_b),
    .rd_in  (rd_in),
    .busy   (busy),
    .done   (done),
    .result (result),
    .rd_out (rd_out)
  );

  always #5 clk = ~clk;

  // Architectural result of an RV32M op computed with plain 64-bit arithmetic
  function automatic logic [31:0] ref_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    logic [31:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    r  = 32'd0;
    case (f)
      3'd0: begin p = 64'(sa * sb); r = p[31:0]; end
      3'd1: begin p = 64'(sa * sb); r = p[63:32]; end
      3'd2: begin p = 64'(sa * ub); r = p[63:32]; end
      3'd3: begin p = 64'(ua * ub); r = p[63:32]; end
      3'd4: begin
        if (b == 32'd0) r = 32'hFFFF_FFFF;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'h8000_0000;
        else begin p = 64'(sa / sb); r = p[31:0]; end
      end
      3'd5: r = (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 32'd0) r = a;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'd0;
        else begin p = 64'(sa % sb); r = p[31:0]; end
      end
      default: r = (b == 32'd0) ? a : a % b;
    endcase
    return r;
  endfunction

  function automatic bit ref_fast(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    return f[2] && ((b == 32'd0) || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
  endfunction

  // Reference model: cycles remaining until IDLE; done is the last busy cycle
  int          m_cnt;
  logic [31:0] m_res;
  logic [31:0] m_pend;
  logic [4:0]  m_rd;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cnt  <= 0;
      m_res  <= 32'd0;
      m_pend <= 32'd0;
      m_rd   <= 5'd0;
    end else if (m_cnt == 0) begin
      if (start) begin
        m_rd <= rd_in;
        if (ref_fast(funct3, op_a, op_b)) begin
          m_cnt <= 1;
          m_res <= ref_op(funct3, op_a, op_b);
        end else begin
          m_cnt  <= 33;
          m_pend <= ref_op(funct3, op_a, op_b);
        end
      end
    end else begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 2) m_res <= m_pend;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=0x%08h expected=0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of every output against the model
  always @(negedge clk) begin
    if (!rst) begin
      chk("busy", {31'd0, busy}, {31'd0, (m_cnt != 0)});
      chk("done", {31'd0, done}, {31'd0, (m_cnt == 1)});
      chk("result", result, m_res);
      chk("rd_out", {27'd0, rd_out}, {27'd0, m_rd});
    end
  end

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return $urandom_range(0, 20);
      default: return $urandom;
    endcase
  endfunction

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (busy) chk("idle timeout", 32'd1, 32'd0);
  endtask

  // Issue one op at a negedge, measure done latency in cycles after the accept edge
  task automatic run_op(input string nm, input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input logic [31:0] exp, input int exp_lat, input bit hold);
    int k;
    int pulses;
    bit seen;
    wait_idle();
    start  = 1'b1;
    funct3 = f;
    op_a   = a;
    op_b   = b;
    rd_in  = rd;
    k = 0;
    pulses = 0;
    seen = 1'b0;
    while (!seen && k < 40) begin
      @(negedge clk);
      k++;
      if (hold) begin
        funct3 = 3'($urandom_range(0, 7));
        op_a   = $urandom;
        op_b   = $urandom;
        rd_in  = 5'($urandom_range(0, 31));
      end else begin
        start = 1'b0;
      end
      if (done) begin
        seen = 1'b1;
        pulses++;
      end
    end
    start = 1'b0;
    chk({nm, " latency"}, 32'(k), 32'(exp_lat));
    chk({nm, " result"}, result, exp);
    chk({nm, " rd_out"}, {27'd0, rd_out}, {27'd0, rd});
    if (hold) begin
      repeat (3) begin
        @(negedge clk);
        if (done) pulses++;
      end
      chk({nm, " done pulses"}, 32'(pulses), 32'd1);
    end
  endtask

  initial begin
    int n_done;
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_done;
    #12;
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset done", {31'd0, done}, 32'd0);
    chk("reset result", result, 32'd0);
    chk("reset rd_out", {27'd0, rd_out}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    run_op("MUL 7*-3", 3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5, 32'hFFFF_FFEB, 33, 1'b0);
    run_op("MULH", 3'd1, 32'h8000_0000, 32'h8000_0000, 5'd6, 32'h4000_0000, 33, 1'b0);
    run_op("MULHU", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7, 32'hFFFF_FFFE, 33, 1'b0);
    run_op("MULHSU", 3'd2, 32'hFFFF_FFFF, 32'd2, 5'd8, 32'hFFFF_FFFF, 33, 1'b0);
    run_op("DIV -7/2", 3'd4, 32'hFFFF_FFF9, 32'd2, 5'd9, 32'hFFFF_FFFD, 33, 1'b0);
    run_op("REM -7/2", 3'd6, 32'hFFFF_FFF9, 32'd2, 5'd10, 32'hFFFF_FFFF, 33, 1'b0);
    run_op("DIVU 7/2", 3'd5, 32'd7, 32'd2, 5'd11, 32'd3, 33, 1'b0);
    run_op("REMU 7/2", 3'd7, 32'd7, 32'd2, 5'd12, 32'd1, 33, 1'b0);
    run_op("DIV 5/0", 3'd4, 32'd5, 32'd0, 5'd13, 32'hFFFF_FFFF, 1, 1'b0);
    run_op("REMU 5/0", 3'd7, 32'd5, 32'd0, 5'd14, 32'd5, 1, 1'b0);
    run_op("DIV ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 32'h8000_0000, 1, 1'b0);
    run_op("REM ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 32'd0, 1, 1'b0);
    run_op("MUL hold", 3'd0, 32'd1000, 32'd3000, 5'd17, 32'd3_000_000, 33, 1'b1);
    run_op("DIVU b2b", 3'd5, 32'd1000, 32'd7, 5'd0, 32'd142, 33, 1'b0);

    // Asynchronous reset in the middle of an iteration
    wait_idle();
    start = 1'b1; funct3 = 3'd5; op_a = 32'd1000; op_b = 32'd3; rd_in = 5'd21;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midreset busy", {31'd0, busy}, 32'd0);
    chk("midreset done", {31'd0, done}, 32'd0);
    chk("midreset result", result, 32'd0);
    #1 rst = 1'b0;
    n_done = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) n_done++;
    end
    chk("no done after reset", 32'(n_done), 32'd0);
    run_op("DIVU 100/7", 3'd5, 32'd100, 32'd7, 5'd3, 32'd14, 33, 1'b0);

    // Random traffic checked cycle by cycle against the model
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      start  = ($urandom_range(0, 3) == 0);
      funct3 = 3'($urandom_range(0, 7));
      op_a   = pick();
      op_b   = pick();
      rd_in  = 5'($urandom_range(0, 31));
    end
    @(negedge clk);
    start = 1'b0;
    wait_idle();
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
